updi_uart_rx: RTL and testbench
===============================

Name: updi_uart_rx

Overview:
- Oversampling asynchronous receiver for the UPDI single-wire link. Frame format is 8E2: start, 8 data bits LSB first, even parity, 2 stop bits.
- Bit timing comes from a divided sample tick, which the clock divider produces at OVERSAMPLE × baud.
- Delivers received bytes through a valid/ready holding register, with per-byte error flags and BREAK detection.
- It is the receive counterpart of the UPDI transmit path.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; even, ≥4.
- STOP_BITS, 2, number of stop bits checked; 1 or 2.

Ports:
- clk_in  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sample_tick  input  1  one-cycle enable pulse at OVERSAMPLE × baud
- rx_enable  input  1  receiver enable; low while the local transmitter drives the wire
- rx  input  1  raw UPDI line; idles high; asynchronous to clk_in
- data  output  8  received byte
- data_valid  output  1  byte available; held until accepted
- data_ready  input  1  consumer accepts the byte when data_valid && data_ready
- parity_err  output  1  parity mismatch for the byte on data; qualified by data_valid
- frame_err  output  1  a stop bit sampled 0 for the byte on data; qualified by data_valid
- overrun  output  1  one or more frames were lost before this byte was accepted; qualified by data_valid
- break_det  output  1  one-cycle pulse on BREAK detection
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - data = 0x00; data_valid, parity_err, frame_err, overrun, break_det, busy = 0.
  - Synchronizer flops = 1. State = IDLE. All counters = 0.
- Input synchronizer: rx passes through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
- Sampling: the FSM advances only on cycles where sample_tick = 1. os_cnt counts ticks within a bit and wraps at OVERSAMPLE-1.
- IDLE:
  - On a tick with rx_enable = 1 and rx_s = 0, go to START with os_cnt = 1.
- START:
  - On the tick where os_cnt reaches OVERSAMPLE/2, sample rx_s.
  - If rx_s = 1, treat it as a glitch and return to IDLE with no output.
  - Otherwise reset os_cnt to 0, set bit_idx = 0, go to DATA.
  - All later samples occur every OVERSAMPLE ticks, i.e. at mid-bit.
- DATA:
  - Each sample shifts into the byte LSB first.
  - After bit_idx = 7, go to PARITY.
- PARITY: sample p; perr = (^byte) ^ p.
- STOP:
  - Take STOP_BITS samples; ferr is set if any sample is 0.
  - If the first stop sample is 0, byte = 0x00 and p = 0, this is a BREAK: go to BRK_WAIT and skip any remaining stop samples.
  - Otherwise, after the last stop sample, commit the frame and return to IDLE.
- BRK_WAIT:
  - Pulse break_det for exactly one clk_in cycle on entry.
  - Stay in BRK_WAIT until rx_s = 1 on a tick, then go to IDLE.
  - Nothing is committed to data/data_valid.
- Commit (the clk_in cycle after the final stop tick):
  - If the holding register is empty, or is being accepted in that same cycle: load data, parity_err, frame_err; set data_valid = 1.
  - Otherwise the new frame is discarded, the held byte is unchanged, and a sticky overrun flag is set.
- overrun output: shows the sticky flag with the currently held byte. The flag clears on the handshake that accepts that byte; set wins if a new discard coincides.
- Handshake:
  - data_valid falls the cycle after data_valid && data_ready.
  - data and the flags stay stable while data_valid = 1 and the byte is not accepted.
- rx_enable low in any state other than IDLE or BRK_WAIT: abort to IDLE next cycle with no commit. A byte already held is unaffected.
- Async reset mid-frame: all state returns to reset values immediately, and a held byte is lost.
- No minimum gap between frames: a new start edge may be detected on the first tick after returning to IDLE.

Test Plan:
- 0x55, parity 0, stops 1,1, data_ready = 1 → data = 0x55, data_valid high for 1 cycle, parity_err = frame_err = overrun = 0, busy low afterwards.
- 0x80 sent with parity 0 (correct is 1) → data = 0x80, parity_err = 1, frame_err = 0.
- rx low for OVERSAMPLE/2 - 2 ticks, then high → no data_valid; busy returns to 0; no break_det.
- Line held low for 13 bit periods, then released → break_det pulses exactly once; data_valid never asserts; the next frame 0xC3 is received correctly.
- data_ready = 0; frames 0x11 then 0x22 back-to-back → data stays 0x11 with overrun = 1. Raise data_ready → 0x11 accepted, data_valid drops, overrun clears.
- rx_enable dropped during data bit 3 of 0xA5 → busy falls, no data_valid. rx_enable restored, 0x3C sent → data = 0x3C, no errors.

Source files
------------

// File: rtl/updi_uart_rx.sv
// UPDI receive path: oversampled 8E2 (or 8E1) UART receiver with a
// valid/ready holding register, per-byte error flags and BREAK detection.
module updi_uart_rx #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned STOP_BITS  = 2
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       sample_tick,
   input  logic       rx_enable,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun,
   output logic       break_det,
   output logic       busy
);

   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] OS_MAX = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] OS_MID = CW'(OVERSAMPLE / 2);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, BRK_WAIT
   } state_t;

   state_t          state, state_next;
   logic            rx_meta, rx_s;
   logic [CW-1:0]   os_cnt;
   logic [2:0]      bit_idx;
   logic            stop_idx;
   logic [7:0]      shreg;
   logic            par_bit, perr, ferr;
   logic            sample, is_break, commit_req, commit_pend, brk_enter;
   logic            accept;

   assign sample   = sample_tick && (os_cnt == OS_MAX);
   assign is_break = (stop_idx == 1'b0) && !rx_s && (shreg == 8'h00) && !par_bit;
   assign accept   = data_valid && data_ready;

   // two-flop synchronizer for the asynchronous line
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // state register
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // next-state logic; receiving states abort to IDLE when the receiver is disabled
   always_comb begin
      state_next = state;
      case (state)
         IDLE:
            if (sample_tick && rx_enable && !rx_s) state_next = START;
         START:
            if (!rx_enable) state_next = IDLE;
            else if (sample_tick && os_cnt == OS_MID) state_next = rx_s ? IDLE : DATA;
         DATA:
            if (!rx_enable) state_next = IDLE;
            else if (sample && bit_idx == 3'd7) state_next = PARITY;
         PARITY:
            if (!rx_enable) state_next = IDLE;
            else if (sample) state_next = STOP;
         STOP:
            if (!rx_enable) state_next = IDLE;
            else if (sample) begin
               if (is_break) state_next = BRK_WAIT;
               else if (stop_idx == LAST_STOP) state_next = IDLE;
            end
         BRK_WAIT:
            if (sample_tick && rx_s) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // output decode: busy, frame commit request, BREAK entry
   always_comb begin
      busy       = (state != IDLE);
      commit_req = (state == STOP) && rx_enable && sample && !is_break && (stop_idx == LAST_STOP);
      brk_enter  = (state_next == BRK_WAIT) && (state != BRK_WAIT);
   end

   // bit timing counters, shift register and per-frame error capture
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         os_cnt   <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
      end else if (sample_tick) begin
         case (state)
            IDLE: os_cnt <= CW'(1);
            START:
               if (os_cnt == OS_MID) begin
                  os_cnt  <= '0;
                  bit_idx <= '0;
                  ferr    <= 1'b0;
               end else begin
                  os_cnt <= os_cnt + 1'b1;
               end
            DATA, PARITY, STOP: begin
               os_cnt <= (os_cnt == OS_MAX) ? '0 : os_cnt + 1'b1;
               if (os_cnt == OS_MAX) begin
                  if (state == DATA) begin
                     shreg   <= {rx_s, shreg[7:1]};
                     bit_idx <= bit_idx + 1'b1;
                  end else if (state == PARITY) begin
                     par_bit  <= rx_s;
                     perr     <= (^shreg) ^ rx_s;
                     stop_idx <= 1'b0;
                  end else begin
                     ferr     <= ferr | !rx_s;
                     stop_idx <= stop_idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // commit one cycle after the last stop sample so ferr includes it
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         commit_pend <= 1'b0;
         break_det   <= 1'b0;
      end else begin
         commit_pend <= commit_req;
         break_det   <= brk_enter;
      end
   end

   // holding register with sticky overrun; a discard keeps the held byte
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         data       <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else if (commit_pend && (!data_valid || data_ready)) begin
         data       <= shreg;
         parity_err <= perr;
         frame_err  <= ferr;
         data_valid <= 1'b1;
         overrun    <= 1'b0;
      end else if (commit_pend) begin
         overrun <= 1'b1;
      end else if (accept) begin
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_updi_uart_rx.sv
// Directed bench for updi_uart_rx: frames, parity error, glitch, BREAK,
// overrun and receiver-disable abort.
module tb_updi_uart_rx;

   localparam int unsigned OS = 16;

   logic       clk_in = 1'b0;
   logic       rst_n = 1'b0;
   logic       sample_tick = 1'b0;
   logic       rx_enable = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       data_valid;
   logic       data_ready = 1'b1;
   logic       parity_err, frame_err, overrun, break_det, busy;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   // monitor state
   logic [7:0]  acc_data = '0;
   logic        acc_perr = 1'b0, acc_ferr = 1'b0, acc_ovr = 1'b0;
   int unsigned acc_cnt = 0, vld_cycles = 0, brk_cycles = 0;
   logic [1:0]  tdiv = '0;

   updi_uart_rx #(.OVERSAMPLE(OS), .STOP_BITS(2)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .sample_tick(sample_tick),
      .rx_enable(rx_enable), .rx(rx), .data(data), .data_valid(data_valid),
      .data_ready(data_ready), .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun), .break_det(break_det), .busy(busy)
   );

   always #5 clk_in = ~clk_in;

   // sample tick every 4 clocks
   always @(posedge clk_in) begin
      tdiv        <= tdiv + 2'd1;
      sample_tick <= (tdiv == 2'd3);
   end

   // observe handshakes and pulses away from the active edge
   always @(negedge clk_in) begin
      if (data_valid) vld_cycles++;
      if (break_det) brk_cycles++;
      if (data_valid && data_ready) begin
         acc_cnt++;
         acc_data = data;
         acc_perr = parity_err;
         acc_ferr = frame_err;
         acc_ovr  = overrun;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk_in);
         while (!sample_tick) @(posedge clk_in);
      end
      #1;
   endtask

   task automatic send_bit(input logic b, input int unsigned ticks);
      rx = b;
      wait_ticks(ticks);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic p, input logic s1, input logic s2);
      send_bit(1'b0, OS);
      for (int i = 0; i < 8; i++) send_bit(b[i], OS);
      send_bit(p, OS);
      send_bit(s1, OS);
      send_bit(s2, OS);
      rx = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned a0, v0, b0;
      #23;
      check("rst_data", data, 8'h00);
      check("rst_valid", data_valid, 0);
      check("rst_flags", {parity_err, frame_err, overrun, break_det, busy}, 0);
      rst_n = 1'b1;
      wait_ticks(4);

      // good frame 0x55
      a0 = acc_cnt; v0 = vld_cycles;
      send_frame(8'h55, 1'b0, 1'b1, 1'b1);
      wait_ticks(4);
      check("f55_cnt", acc_cnt - a0, 1);
      check("f55_vld_cycles", vld_cycles - v0, 1);
      check("f55_data", acc_data, 8'h55);
      check("f55_flags", {acc_perr, acc_ferr, acc_ovr}, 3'b000);
      check("f55_busy", busy, 0);

      // parity error
      send_frame(8'h80, 1'b0, 1'b1, 1'b1);
      wait_ticks(4);
      check("f80_data", acc_data, 8'h80);
      check("f80_perr", acc_perr, 1);
      check("f80_ferr", acc_ferr, 0);

      // start glitch shorter than half a bit
      a0 = acc_cnt; b0 = brk_cycles;
      send_bit(1'b0, OS / 2 - 2);
      send_bit(1'b1, 2 * OS);
      check("glitch_cnt", acc_cnt - a0, 0);
      check("glitch_busy", busy, 0);
      check("glitch_brk", brk_cycles - b0, 0);

      // BREAK: 13 bit periods low
      a0 = acc_cnt; b0 = brk_cycles;
      send_bit(1'b0, 13 * OS);
      send_bit(1'b1, OS);
      check("brk_pulse", brk_cycles - b0, 1);
      check("brk_nodata", acc_cnt - a0, 0);
      check("brk_busy", busy, 0);
      send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
      wait_ticks(4);
      check("fC3_cnt", acc_cnt - a0, 1);
      check("fC3_data", acc_data, 8'hC3);
      check("fC3_flags", {acc_perr, acc_ferr}, 2'b00);

      // overrun: two frames while consumer stalls
      data_ready = 1'b0;
      a0 = acc_cnt;
      send_frame(8'h11, 1'b0, 1'b1, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1, 1'b1);
      wait_ticks(4);
      check("ovr_valid", data_valid, 1);
      check("ovr_data", data, 8'h11);
      check("ovr_flag", overrun, 1);
      @(negedge clk_in);
      data_ready = 1'b1;
      @(negedge clk_in);
      check("ovr_acc_data", acc_data, 8'h11);
      check("ovr_acc_ovr", acc_ovr, 1);
      check("ovr_cnt", acc_cnt - a0, 1);
      check("ovr_valid_drop", data_valid, 0);
      check("ovr_clear", overrun, 0);

      // receiver disabled mid-frame during data bit 3 of 0xA5
      a0 = acc_cnt;
      send_bit(1'b0, OS);
      send_bit(1'b1, OS);
      send_bit(1'b0, OS);
      send_bit(1'b1, OS);
      send_bit(1'b0, OS / 2);
      rx_enable = 1'b0;
      @(posedge clk_in); @(posedge clk_in); #1;
      check("abort_busy", busy, 0);
      send_bit(1'b1, 6 * OS);
      rx_enable = 1'b1;
      check("abort_nodata", acc_cnt - a0, 0);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
      wait_ticks(4);
      check("f3C_cnt", acc_cnt - a0, 1);
      check("f3C_data", acc_data, 8'h3C);
      check("f3C_flags", {acc_perr, acc_ferr, acc_ovr}, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
